// File: rtl/sprite_pkg.sv
// Shared sprite codes and animation state types for the player sprite path.
// Also imported by the sprite multiplexer.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    JUMP,
    ROLL
  } anim_state_t;

  typedef enum logic [1:0] {
    MODE_HOLD,
    MODE_WRAP,
    MODE_SAT
  } anim_mode_t;

  localparam logic [3:0] SEL_IDLE_R = 4'd0;
  localparam logic [3:0] SEL_IDLE_L = 4'd1;
  localparam logic [3:0] SEL_WALK_R = 4'd2;
  localparam logic [3:0] SEL_WALK_L = 4'd3;
  localparam logic [3:0] SEL_JUMP_R = 4'd4;
  localparam logic [3:0] SEL_JUMP_L = 4'd5;
  localparam logic [3:0] SEL_ROLL   = 4'd6;

  function automatic logic [3:0] sel_code(
    input anim_state_t s,
    input logic        left
  );
    logic [3:0] code;
    unique case (s)
      IDLE:    code = left ? SEL_IDLE_L : SEL_IDLE_R;
      WALK:    code = left ? SEL_WALK_L : SEL_WALK_R;
      JUMP:    code = left ? SEL_JUMP_L : SEL_JUMP_R;
      default: code = SEL_ROLL;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/anim_frame_counter.sv
// Step counter plus 2-bit animation frame index.
// Advances once every FRAMES_PER_STEP ticks; wraps, saturates or holds.
module anim_frame_counter
  import sprite_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       clear,
  input  anim_mode_t mode,
  output logic [1:0] anim_frame
);

  localparam int unsigned SW = $clog2(FRAMES_PER_STEP + 1);

  logic [SW-1:0] step_q, step_d;
  logic [1:0]    frame_q, frame_d;
  logic          wrap;

  always_comb begin
    step_d  = step_q;
    frame_d = frame_q;
    wrap    = (step_q == SW'(FRAMES_PER_STEP - 1));
    if (tick) begin
      if (clear) begin
        step_d  = '0;
        frame_d = '0;
      end else begin
        step_d = wrap ? '0 : step_q + 1'b1;
        if (wrap) begin
          unique case (mode)
            MODE_WRAP: frame_d = frame_q + 2'd1;
            MODE_SAT:  frame_d = (frame_q == 2'd3) ? 2'd3
                               : frame_q + 2'd1;
            default:   frame_d = 2'd0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q  <= '0;
      frame_q <= '0;
    end else begin
      step_q  <= step_d;
      frame_q <= frame_d;
    end
  end

  assign anim_frame = frame_q;

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Player sprite select / animation frame controller, one update per frame.
// Optional roll move enabled by defining SPRITE_ANIM_ROLL_EN.
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = 6,
  parameter int unsigned ROLL_FRAMES     = 24
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic       key_roll,
  input  logic       on_ground,
  output logic [3:0] sel,
  output logic [1:0] anim_frame,
  output logic       jump_start
);

  anim_state_t state_q, state_d;
  anim_state_t key_state;
  anim_mode_t  mode;
  logic        left_q, left_d;
  logic        airborne_q, airborne_d;
  logic        jump_prev_q, jump_prev_d;
  logic [3:0]  sel_q, sel_d;
  logic        jump_start_q, jump_start_d;
  logic        jump_go, jump_edge, roll_go, anim_clear;

`ifdef SPRITE_ANIM_ROLL_EN
  logic [7:0] roll_cnt_q, roll_cnt_d;
  assign roll_go = key_roll & on_ground & ~key_jump;
`else
  logic unused_roll;
  assign roll_go     = 1'b0;
  assign unused_roll = key_roll & (ROLL_FRAMES > 0);
`endif

  assign jump_edge = key_jump & ~jump_prev_q;
  assign key_state = (key_left ^ key_right) ? WALK : IDLE;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      left_q       <= 1'b0;
      airborne_q   <= 1'b0;
      jump_prev_q  <= 1'b0;
      sel_q        <= SEL_IDLE_R;
      jump_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      left_q       <= left_d;
      airborne_q   <= airborne_d;
      jump_prev_q  <= jump_prev_d;
      sel_q        <= sel_d;
      jump_start_q <= jump_start_d;
    end
  end

`ifdef SPRITE_ANIM_ROLL_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) roll_cnt_q <= '0;
    else          roll_cnt_q <= roll_cnt_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    left_d      = left_q;
    airborne_d  = airborne_q;
    jump_prev_d = jump_prev_q;
    jump_go     = 1'b0;
`ifdef SPRITE_ANIM_ROLL_EN
    roll_cnt_d  = roll_cnt_q;
`endif
    if (frame_tick) begin
      jump_prev_d = key_jump;
      if (key_left & ~key_right)      left_d = 1'b1;
      else if (key_right & ~key_left) left_d = 1'b0;
      unique case (state_q)
        IDLE, WALK: begin
          if (jump_edge & on_ground) begin
            state_d    = JUMP;
            airborne_d = 1'b0;
            jump_go    = 1'b1;
          end else if (roll_go) begin
            state_d = ROLL;
`ifdef SPRITE_ANIM_ROLL_EN
            roll_cnt_d = '0;
`endif
          end else begin
            state_d = key_state;
          end
        end
        JUMP: begin
          if (!on_ground)      airborne_d = 1'b1;
          else if (airborne_q) state_d    = key_state;
        end
        default: begin
`ifdef SPRITE_ANIM_ROLL_EN
          if (roll_cnt_q == 8'(ROLL_FRAMES - 1)) begin
            state_d    = key_state;
            roll_cnt_d = '0;
          end else begin
            roll_cnt_d = roll_cnt_q + 8'd1;
          end
`else
          state_d = key_state;
`endif
        end
      endcase
    end
  end

  always_comb begin
    sel_d        = sel_code(state_d, left_d);
    jump_start_d = jump_go;
    anim_clear   = (state_d != state_q) | (left_d != left_q);
    unique case (state_q)
      IDLE:    mode = MODE_HOLD;
      JUMP:    mode = MODE_SAT;
      default: mode = MODE_WRAP;
    endcase
  end

  anim_frame_counter #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_frame_cnt (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .tick      (frame_tick),
    .clear     (anim_clear),
    .mode      (mode),
    .anim_frame(anim_frame)
  );

  assign sel        = sel_q;
  assign jump_start = jump_start_q;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Bench for sprite_anim_ctrl: directed scenarios plus randomized traffic
// against a behavioural model of the animation rules.
module tb_sprite_anim_ctrl;

  localparam int FPS = 6;
  localparam int RF  = 24;
`ifdef SPRITE_ANIM_ROLL_EN
  localparam bit ROLL_EN = 1'b1;
`else
  localparam bit ROLL_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       key_left = 1'b0;
  logic       key_right = 1'b0;
  logic       key_jump = 1'b0;
  logic       key_roll = 1'b0;
  logic       on_ground = 1'b1;
  logic [3:0] sel;
  logic [1:0] anim_frame;
  logic       jump_start;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // model: 0 idle, 1 walk, 2 jump, 3 roll
  int m_mode;
  bit m_left, m_air, m_prev;
  int m_roll_age;
  int m_since;
  int exp_sel, exp_anim;
  bit exp_js;
  bit js_cap;

  sprite_anim_ctrl #(
    .FRAMES_PER_STEP(FPS),
    .ROLL_FRAMES    (RF)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_tick(frame_tick),
    .key_left  (key_left),
    .key_right (key_right),
    .key_jump  (key_jump),
    .key_roll  (key_roll),
    .on_ground (on_ground),
    .sel       (sel),
    .anim_frame(anim_frame),
    .jump_start(jump_start)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_out();
    int steps;
    steps = m_since / FPS;
    exp_sel = (m_mode == 3) ? 6 : m_mode * 2 + int'(m_left);
    case (m_mode)
      0:       exp_anim = 0;
      2:       exp_anim = (steps > 3) ? 3 : steps;
      default: exp_anim = steps % 4;
    endcase
  endtask

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_air = 0; m_prev = 0;
    m_roll_age = 0; m_since = 0; exp_js = 0;
    model_out();
  endtask

  task automatic model_tick(input bit l, r, j, ro, g);
    int nm, keys;
    bit nl, jedge;
    jedge  = j && !m_prev;
    m_prev = j;
    nl = m_left;
    if (l && !r) nl = 1;
    else if (r && !l) nl = 0;
    keys = (l != r) ? 1 : 0;
    nm = m_mode;
    exp_js = 0;
    case (m_mode)
      0, 1: begin
        if (jedge && g) begin
          nm = 2; m_air = 0; exp_js = 1;
        end else if (ROLL_EN && ro && g && !j) begin
          nm = 3; m_roll_age = 0;
        end else nm = keys;
      end
      2: begin
        if (!g) m_air = 1;
        else if (m_air) nm = keys;
      end
      default: begin
        if (m_roll_age == RF - 1) nm = keys;
        else m_roll_age++;
      end
    endcase
    if (nm != m_mode || nl != m_left) m_since = 0;
    else m_since++;
    m_mode = nm;
    m_left = nl;
    model_out();
  endtask

  task automatic cyc(input bit t, l, r, j, ro, g);
    @(negedge Clk);
    frame_tick = t; key_left = l; key_right = r;
    key_jump = j; key_roll = ro; on_ground = g;
    @(posedge Clk);
    if (!Reset_n) model_reset();
    else if (t) model_tick(l, r, j, ro, g);
    else exp_js = 0;
  endtask

  task automatic tk(input bit l, r, j, ro, g);
    cyc(1, l, r, j, ro, g);
    #1 js_cap = jump_start;
    cyc(0, l, r, j, ro, g);
    cyc(0, l, r, j, ro, g);
    #1;
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("sel", sel, exp_sel);
      chk("anim_frame", anim_frame, exp_anim);
      chk("jump_start", jump_start, int'(exp_js));
    end
  end

  initial begin
    bit t, l, r, j, ro, g;
    model_reset();
    repeat (3) @(negedge Clk);
    chk("reset_sel", sel, 0);
    chk("reset_anim", anim_frame, 0);
    chk("reset_js", jump_start, 0);
    #2 Reset_n = 1'b1;
    cmp_en = 1'b1;

    for (int i = 1; i <= 13; i++) begin
      tk(0, 1, 0, 0, 1);
      if (i == 1) chk("walk_r_sel", sel, 2);
      if (i == 1) chk("walk_first_anim", anim_frame, 0);
      if (i == 6) chk("walk_t6_anim", anim_frame, 0);
      if (i == 7) chk("walk_t7_anim", anim_frame, 1);
      if (i == 13) chk("walk_t13_anim", anim_frame, 2);
    end

    tk(1, 0, 0, 0, 1);
    chk("walk_l_sel", sel, 3);
    tk(0, 0, 0, 0, 1);
    chk("idle_l_sel", sel, 1);
    tk(1, 1, 0, 0, 1);
    chk("both_keys_sel", sel, 1);

    tk(0, 1, 0, 0, 1);
    tk(0, 0, 1, 0, 1);
    chk("jump_pulse", js_cap, 1);
    chk("jump_sel", sel, 4);
    chk("jump_pulse_end", jump_start, 0);
    repeat (5) tk(0, 0, 0, 0, 0);
    chk("air_sel", sel, 4);
    tk(0, 0, 0, 0, 1);
    chk("land_sel", sel, 0);

    tk(0, 0, 1, 0, 1);
    repeat (30) tk(0, 0, 0, 0, 0);
    chk("jump_sat_anim", anim_frame, 3);
    tk(0, 0, 0, 0, 1);

    tk(0, 0, 1, 0, 1);
    repeat (3) tk(0, 0, 1, 0, 0);
    tk(0, 0, 1, 0, 1);
    chk("held_land_sel", sel, 0);
    tk(0, 0, 1, 0, 1);
    chk("held_no_rejump_sel", sel, 0);
    chk("held_no_rejump_js", js_cap, 0);
    tk(0, 0, 0, 0, 1);
    tk(0, 0, 1, 0, 1);
    chk("rejump_js", js_cap, 1);
    chk("rejump_sel", sel, 4);
    tk(0, 0, 0, 0, 0);
    tk(0, 0, 0, 0, 1);

    tk(0, 0, 0, 1, 1);
    if (ROLL_EN) begin
      chk("roll_sel", sel, 6);
      for (int i = 0; i < RF - 1; i++) begin
        tk(0, 0, i % 2 == 1, 0, 1);
        chk("roll_hold_sel", sel, 6);
      end
      tk(0, 0, 0, 0, 1);
      chk("roll_end_sel", sel, 0);
      tk(0, 0, 0, 1, 1);
    end else begin
      chk("no_roll_sel", sel, 0);
      tk(0, 0, 1, 0, 1);
    end
    repeat (7) tk(0, 0, 0, 0, ROLL_EN);
    chk("pre_reset_anim", anim_frame, 1);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_sel", sel, 0);
    chk("async_rst_anim", anim_frame, 0);
    chk("async_rst_js", jump_start, 0);
    repeat (2) cyc(1, 1, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 1);
    @(negedge Clk);
    #2 Reset_n = 1'b1;

    repeat (9) tk(1, 0, 0, 0, 1);
    for (int i = 0; i < 100; i++) begin
      cyc(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1);
    end
    #1;
    chk("frozen_sel", sel, 3);
    chk("frozen_anim", anim_frame, 1);

    g = 1;
    for (int i = 0; i < 6000; i++) begin
      t  = $urandom_range(0, 2) == 0;
      l  = $urandom_range(0, 3) == 0;
      r  = $urandom_range(0, 3) == 0;
      j  = $urandom_range(0, 4) == 0;
      ro = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 7) == 0) g = ~g;
      cyc(t, l, r, j, ro, g);
    end

    @(negedge Clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
